quad_encoder_gen: RTL and testbench

Quadrature encoder emulator: generates A/B channel waveforms for one wheel encoder at a programmable step rate, direction and step count. It drives the encoder inputs of the system processor so that its pulse-measurement path (command opcode 0001, result on dataout) runs against known, repeatable motion. It also keeps a signed position count of emitted steps, which serves as the reference value when checking the measurement path. Four instances, one per encoder bit, sit in the bench and in the hardware self-test top.

---
 rtl/quad_encoder_gen_pkg.sv | 34 +++
 rtl/quad_step_timer.sv | 37 +++
 rtl/quad_encoder_gen.sv | 97 +++++++++
 tb/tb_quad_encoder_gen.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/quad_encoder_gen_pkg.sv
// Shared definitions for the quadrature encoder emulator: phase codes,
// controller states and the shortest allowed step period.
package quad_encoder_gen_pkg;

  // Phase codes are {enc_a, enc_b}; forward order is 00 -> 10 -> 11 -> 01
  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_10 = 2'b10;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_01 = 2'b01;

  // Step periods below this value are raised to it so the timer always has a
  // nonzero reload and each phase lasts at least two clocks
  localparam int MIN_STEP = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // One quadrature step in the requested direction; reverse walks the same
  // ring backwards, so exactly one channel changes per step
  function automatic logic [1:0] next_phase(input logic [1:0] ph, input logic fwd);
    logic [1:0] nxt;
    nxt = PH_00;
    case (ph)
      PH_00:   nxt = fwd ? PH_10 : PH_01;
      PH_10:   nxt = fwd ? PH_11 : PH_00;
      PH_11:   nxt = fwd ? PH_01 : PH_10;
      default: nxt = fwd ? PH_00 : PH_11;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/quad_step_timer.sv
// Loadable down-counter that ticks when it reaches zero and then reloads
// itself with the value captured at the last load.
module quad_step_timer #(
  parameter int W = 16
) (
  input  logic         clk_sys,
  input  logic         rst,
  input  logic         load,
  input  logic         enable,
  input  logic [W-1:0] load_value,
  output logic         tick
);

  logic [W-1:0] count;
  logic [W-1:0] reload;

  // Count down while enabled; zero is the tick cycle, after which the
  // stored period is restored for the next step
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      count  <= '0;
      reload <= '0;
    end else if (load) begin
      count  <= load_value;
      reload <= load_value;
    end else if (enable) begin
      if (count == '0) begin
        count <= reload;
      end else begin
        count <= count - W'(1);
      end
    end
  end

  assign tick = enable && (count == '0);

endmodule

// File: rtl/quad_encoder_gen.sv
// Quadrature encoder emulator: emits A/B steps at a programmed period and
// direction, for a fixed count or until stopped, and tracks signed position.
module quad_encoder_gen
  import quad_encoder_gen_pkg::*;
#(
  parameter int STEP_W = 16,
  parameter int POS_W  = 16
) (
  input  logic              clk_sys,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              dir,
  input  logic [STEP_W-1:0] step_cycles,
  input  logic [STEP_W-1:0] num_steps,
  output logic              enc_a,
  output logic              enc_b,
  output logic              busy,
  output logic              done,
  output logic [POS_W-1:0]  position
);

  state_t            state;
  logic [1:0]        phase;
  logic              dir_q;
  logic [STEP_W-1:0] num_q;
  logic [STEP_W-1:0] steps_done;
  logic [STEP_W-1:0] steps_next;
  logic [STEP_W-1:0] step_clamped;
  logic              launch;
  logic              tick;

  // A run begins only from IDLE and only when stop is not also requested
  assign launch       = (state == IDLE) && start && !stop;
  assign step_clamped = (step_cycles < STEP_W'(MIN_STEP)) ? STEP_W'(MIN_STEP) : step_cycles;
  assign steps_next   = (steps_done == '1) ? steps_done : steps_done + STEP_W'(1);

  quad_step_timer #(
    .W (STEP_W)
  ) u_timer (
    .clk_sys    (clk_sys),
    .rst        (rst),
    .load       (launch),
    .enable     (state == RUN),
    .load_value (step_clamped - STEP_W'(1)),
    .tick       (tick)
  );

  // Run controller: stop wins over a coincident step, and the last counted
  // step drops busy on the same edge that moves the outputs
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state      <= IDLE;
      phase      <= PH_00;
      position   <= '0;
      steps_done <= '0;
      num_q      <= '0;
      dir_q      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (launch) begin
            state      <= RUN;
            busy       <= 1'b1;
            dir_q      <= dir;
            num_q      <= num_steps;
            steps_done <= '0;
          end
        end
        RUN: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (tick) begin
            phase      <= next_phase(phase, dir_q);
            position   <= dir_q ? position + POS_W'(1) : position - POS_W'(1);
            steps_done <= steps_next;
            if ((num_q != '0) && (steps_next == num_q)) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign enc_a = phase[1];
  assign enc_b = phase[0];

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Directed bench for the quadrature encoder emulator: a table of runs with
// hand-computed timing and end state, plus reset, wrap and start/stop cases.
module tb_quad_encoder_gen;

  logic        clk_sys = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic        dir;
  logic [15:0] step_cycles;
  logic [15:0] num_steps;
  logic        enc_a;
  logic        enc_b;
  logic        busy;
  logic        done;
  logic [15:0] position;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0] ab_log [0:15];

  typedef struct {
    logic       dir;
    int         sc;
    int         ns;
    int         stop_at;
    int         restart_at;
    int         exp_busy;
    int         exp_toggles;
    int         exp_first;
    int         exp_last;
    int         exp_done;
    logic [1:0] exp_ab;
    int         exp_pos;
  } vec_t;

  vec_t vecs [6];

  quad_encoder_gen #(
    .STEP_W (16),
    .POS_W  (16)
  ) dut (
    .clk_sys     (clk_sys),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .dir         (dir),
    .step_cycles (step_cycles),
    .num_steps   (num_steps),
    .enc_a       (enc_a),
    .enc_b       (enc_b),
    .busy        (busy),
    .done        (done),
    .position    (position)
  );

  // Free-running system clock
  always #5 clk_sys = ~clk_sys;

  // Hard time limit so a stuck design still ends the run
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Launch one run and observe it at every falling edge; t counts rising
  // edges after the one that sampled start
  task automatic apply_stimulus(input logic d, input int sc, input int ns,
                                input int stop_at, input int restart_at, input int bound,
                                output int busy_cyc, output int toggles,
                                output int first_t, output int last_t,
                                output int done_cnt, output int one_bit_err,
                                output bit timed_out);
    logic [1:0] prev;
    int t;
    int idle_after;
    busy_cyc = 0; toggles = 0; first_t = -1; last_t = -1;
    done_cnt = 0; one_bit_err = 0; timed_out = 1'b0;
    t = 0; idle_after = 0;
    @(negedge clk_sys);
    prev        = {enc_a, enc_b};
    dir         = d;
    step_cycles = sc[15:0];
    num_steps   = ns[15:0];
    start       = 1'b1;
    @(negedge clk_sys);
    start = 1'b0;
    while (1) begin
      if (busy) busy_cyc++;
      if (done) done_cnt++;
      if ({enc_a, enc_b} != prev) begin
        if (toggles < 16) ab_log[toggles] = {enc_a, enc_b};
        if ($countones({enc_a, enc_b} ^ prev) != 1) one_bit_err++;
        toggles++;
        if (first_t < 0) first_t = t;
        last_t = t;
        prev = {enc_a, enc_b};
      end
      if (!busy) idle_after++;
      if (idle_after >= 3) break;
      if (t >= bound) begin
        timed_out = 1'b1;
        break;
      end
      stop = (stop_at > 0) && (t + 1 == stop_at);
      if ((restart_at > 0) && (t + 1 == restart_at)) begin
        start       = 1'b1;
        dir         = ~d;
        step_cycles = 16'd7;
        num_steps   = 16'd1;
      end else begin
        start       = 1'b0;
        dir         = d;
        step_cycles = sc[15:0];
        num_steps   = ns[15:0];
      end
      @(negedge clk_sys);
      t++;
    end
    stop  = 1'b0;
    start = 1'b0;
  endtask

  task automatic run_vector(input int i, input string tag);
    int busy_cyc, toggles, first_t, last_t, done_cnt, one_bit_err;
    bit timed_out;
    logic [1:0] seq1 [8];
    logic [1:0] seq2 [3];
    seq1 = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b10, 2'b11, 2'b01, 2'b00};
    seq2 = '{2'b01, 2'b11, 2'b10};
    apply_stimulus(vecs[i].dir, vecs[i].sc, vecs[i].ns, vecs[i].stop_at, vecs[i].restart_at,
                   2000, busy_cyc, toggles, first_t, last_t, done_cnt, one_bit_err, timed_out);
    check_output($sformatf("%s%0d timeout", tag, i), 32'(timed_out), 32'd0);
    check_output($sformatf("%s%0d busy_cycles", tag, i), busy_cyc, vecs[i].exp_busy);
    check_output($sformatf("%s%0d toggles", tag, i), toggles, vecs[i].exp_toggles);
    check_output($sformatf("%s%0d first_toggle", tag, i), first_t, vecs[i].exp_first);
    check_output($sformatf("%s%0d last_toggle", tag, i), last_t, vecs[i].exp_last);
    check_output($sformatf("%s%0d done_pulses", tag, i), done_cnt, vecs[i].exp_done);
    check_output($sformatf("%s%0d one_bit_steps", tag, i), one_bit_err, 0);
    check_output($sformatf("%s%0d ab_final", tag, i), {enc_a, enc_b}, vecs[i].exp_ab);
    check_output($sformatf("%s%0d position", tag, i), position, vecs[i].exp_pos);
    if (i == 0) begin
      for (int s = 0; s < 8; s++)
        check_output($sformatf("%s%0d ab_step%0d", tag, i, s), ab_log[s], seq1[s]);
    end
    if (i == 1) begin
      for (int s = 0; s < 3; s++)
        check_output($sformatf("%s%0d ab_step%0d", tag, i, s), ab_log[s], seq2[s]);
    end
  endtask

  initial begin
    int busy_cyc, toggles, first_t, last_t, done_cnt, one_bit_err;
    bit timed_out;
    bit any_busy, any_done;
    logic [15:0] pos_before;

    rst = 1'b1; start = 1'b0; stop = 1'b0; dir = 1'b0;
    step_cycles = '0; num_steps = '0;

    //              dir   sc ns stop rst busy tog first last done ab     pos
    vecs[0] = '{1'b1, 10, 8, 0,  0,  80,  8,  10,  80,  1, 2'b00, 8};
    vecs[1] = '{1'b0, 4,  3, 0,  0,  12,  3,  4,   12,  1, 2'b10, 5};
    vecs[2] = '{1'b1, 5,  0, 23, 0,  23,  4,  5,   20,  1, 2'b10, 9};
    vecs[3] = '{1'b1, 5,  0, 25, 0,  25,  4,  5,   20,  1, 2'b10, 13};
    vecs[4] = '{1'b1, 0,  3, 0,  0,  6,   3,  2,   6,   1, 2'b00, 16};
    vecs[5] = '{1'b0, 1,  4, 0,  3,  8,   4,  2,   8,   1, 2'b00, 12};

    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    check_output("reset enc_a", enc_a, 0);
    check_output("reset enc_b", enc_b, 0);
    check_output("reset busy", busy, 0);
    check_output("reset done", done, 0);
    check_output("reset position", position, 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_vector(i, "vec");

    // start and stop together while idle must not launch a run
    @(negedge clk_sys);
    pos_before = position;
    start = 1'b1; stop = 1'b1; dir = 1'b1; step_cycles = 16'd2; num_steps = 16'd1;
    any_busy = 1'b0; any_done = 1'b0;
    @(negedge clk_sys);
    start = 1'b0; stop = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (busy) any_busy = 1'b1;
      if (done) any_done = 1'b1;
      @(negedge clk_sys);
    end
    check_output("start_stop busy", any_busy, 0);
    check_output("start_stop done", any_done, 0);
    check_output("start_stop position", position, pos_before);

    // reset in the middle of a run
    dir = 1'b1; step_cycles = 16'd10; num_steps = 16'd8; start = 1'b1;
    @(negedge clk_sys);
    start = 1'b0;
    repeat (24) @(negedge clk_sys);
    check_output("midrun busy", busy, 1);
    check_output("midrun ab", {enc_a, enc_b}, 2'b11);
    check_output("midrun position", position, 14);
    rst = 1'b1;
    @(negedge clk_sys);
    rst = 1'b0;
    check_output("midrun_rst enc_a", enc_a, 0);
    check_output("midrun_rst enc_b", enc_b, 0);
    check_output("midrun_rst busy", busy, 0);
    check_output("midrun_rst position", position, 0);
    any_busy = 1'b0; any_done = done;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_sys);
      if (busy) any_busy = 1'b1;
      if (done) any_done = 1'b1;
    end
    check_output("midrun_rst no_done", any_done, 0);
    check_output("midrun_rst idle", any_busy, 0);
    run_vector(0, "rerun");

    // wrap through the signed boundary
    rst = 1'b1;
    @(negedge clk_sys);
    @(negedge clk_sys);
    rst = 1'b0;
    apply_stimulus(1'b1, 2, 32766, 0, 0, 70000,
                   busy_cyc, toggles, first_t, last_t, done_cnt, one_bit_err, timed_out);
    check_output("preload timeout", 32'(timed_out), 0);
    check_output("preload position", position, 32'h7FFE);
    check_output("preload ab", {enc_a, enc_b}, 2'b11);
    check_output("preload busy_cycles", busy_cyc, 65532);
    apply_stimulus(1'b1, 2, 3, 0, 0, 2000,
                   busy_cyc, toggles, first_t, last_t, done_cnt, one_bit_err, timed_out);
    check_output("wrap position", position, 32'h8001);
    check_output("wrap ab", {enc_a, enc_b}, 2'b10);
    check_output("wrap done_pulses", done_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
